// File: rtl/int2mfp.sv
// int2mfp: 8-bit two's-complement integer to 9-bit minifloat {0, sign, exp[2:0], frac[3:0]}
// using a shift-per-cycle normaliser. Define MFP_ROUND_NEAREST_EN for round-half-to-even; default truncates.
module int2mfp (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] int_in,
    output logic [8:0] result_9,
    output logic       z,
    output logic       ovf,
    output logic       inexact,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

    state_t     state_q;
    logic       sign_q;
    logic [7:0] mag_q;
    logic [3:0] exp_q;
    logic [8:0] result_q;
    logic       z_q, ovf_q, inexact_q, busy_q, done_q;

    logic [7:0] mag_in;
    logic [3:0] frac;
    logic       guard, sticky;
    logic [8:0] result_d;
    logic       z_d, ovf_d, inexact_d;
`ifdef MFP_ROUND_NEAREST_EN
    logic [4:0] frac_rnd;
`endif

    // -128 negates to itself, which reads correctly as magnitude 8'h80.
    assign mag_in = int_in[7] ? (~int_in + 8'd1) : int_in;

    assign frac   = mag_q[6:3];
    assign guard  = mag_q[2];
    assign sticky = |mag_q[1:0];

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        result_d  = {1'b0, sign_q, exp_q[2:0], frac};
        z_d       = 1'b0;
        ovf_d     = 1'b0;
        inexact_d = guard | sticky;
`ifdef MFP_ROUND_NEAREST_EN
        frac_rnd  = {1'b0, frac} + 5'd1;
`endif
        if (mag_q == 8'd0) begin
            result_d  = 9'h000;
            z_d       = 1'b1;
            inexact_d = 1'b0;
        end else if (exp_q == 4'd8) begin
            result_d  = {1'b0, sign_q, 7'h7F};
            ovf_d     = 1'b1;
            inexact_d = 1'b1;
        end
`ifdef MFP_ROUND_NEAREST_EN
        else if (guard && (sticky || frac[0])) begin
            if (!frac_rnd[4]) begin
                result_d = {1'b0, sign_q, exp_q[2:0], frac_rnd[3:0]};
            end else if (exp_q[2:0] != 3'd7) begin
                result_d = {1'b0, sign_q, exp_q[2:0] + 3'd1, 4'h0};
            end else begin
                result_d = {1'b0, sign_q, 7'h7F};
                ovf_d    = 1'b1;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            mag_q     <= 8'd0;
            exp_q     <= 4'd0;
            result_q  <= 9'h000;
            z_q       <= 1'b0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= int_in[7];
                        mag_q   <= mag_in;
                        exp_q   <= 4'd8;
                        busy_q  <= 1'b1;
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (mag_q == 8'd0 || mag_q[7]) begin
                        state_q <= PACK;
                    end else begin
                        mag_q <= {mag_q[6:0], 1'b0};
                        exp_q <= exp_q - 4'd1;
                    end
                end
                PACK: begin
                    result_q  <= result_d;
                    z_q       <= z_d;
                    ovf_q     <= ovf_d;
                    inexact_q <= inexact_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_9 = result_q;
    assign z        = z_q;
    assign ovf      = ovf_q;
    assign inexact  = inexact_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
